scs8hd_pgate_seq: RTL and testbench
===================================

Name: scs8hd_pgate_seq

Overview:
- Power-gating sequencer for one switchable scs8hd power domain: ramps the header-switch chain stage by stage, then drives domain reset, retention restore/save and output isolation in a fixed safe order.
- Sits in the always-on domain between the PMU request/ack handshake and the domain's switch, isolation and retention cells.
- All outputs are registered; powered from the always-on vpwr/vgnd.

Parameters:
NSTG, 4, number of header-switch stages (1..16)
STG_DLY, 8, cycles between successive stage enables/disables and settle after the final stage (>=1)
RST_DLY, 4, extra cycles dom_reset is held after the switches are fully on (>=1)
ISO_DLY, 2, isolation setup/hold cycles (>=1)

Ports:
clk  input  1  sequencer clock (always-on)
reset  input  1  asynchronous, active-high reset
pwr_req  input  1  level request from PMU: 1 = domain on, 0 = domain off
pwr_ack  output  1  1 only in ON state
sw_en  output  NSTG  header-switch stage enables; bit 0 is switched on first and off last
iso_en  output  1  1 = domain outputs clamped
dom_reset  output  1  active-high reset into the gated domain
ret_restore  output  1  single-cycle retention restore pulse
ret_save  output  1  single-cycle retention save pulse
busy  output  1  1 in every state except ON and OFF

Behaviour:
- One clock, clk. reset is asynchronous and active-high and forces OFF: sw_en=0, iso_en=1, dom_reset=1, ret_save=0, ret_restore=0, pwr_ack=0, busy=0. reset asserted mid-sequence aborts immediately to these values with no save pulse.
- States: OFF, UP, RST, RESTORE, UNISO, ON, ISO, SAVE, DOWN. One shared down-counter, width clog2(max(NSTG*STG_DLY, RST_DLY, ISO_DLY)+1), and a stage index.
- OFF: outputs as at reset. pwr_req=1 sampled at edge E0 -> UP.
- UP: sw_en[0]=1 from E0. sw_en[k] sets at E0+k*STG_DLY. UP lasts NSTG*STG_DLY cycles -> RST.
- RST: dom_reset stays 1 for RST_DLY cycles, then deasserts on entry to RESTORE.
- RESTORE: ret_restore=1 for exactly one cycle -> UNISO.
- UNISO: iso_en stays 1 for ISO_DLY cycles -> ON. On that edge iso_en=0 and pwr_ack=1.
- ON: outputs are sw_en all ones, iso_en=0, dom_reset=0, pwr_ack=1. pwr_req=0 sampled at edge E0 -> ISO. At E0, pwr_ack=0 and iso_en=1.
- ISO: ISO_DLY cycles -> SAVE.
- SAVE: ret_save=1 for exactly one cycle -> DOWN.
- DOWN: dom_reset=1 on entry. sw_en[NSTG-1] clears on entry and each lower bit clears STG_DLY cycles later. DOWN lasts NSTG*STG_DLY cycles -> OFF.
- pwr_req is sampled only in OFF and ON. Toggles during any busy state are ignored; the current level is re-evaluated on arrival in ON/OFF, so a request reversed mid-sequence completes the sequence and then immediately starts the reverse one.
- Invariants (assertable):
  - iso_en=1 whenever any sw_en bit is 0 or dom_reset=1.
  - ret_save and ret_restore are never high together.
  - sw_en is always thermometer-coded from bit 0.
  - pwr_ack implies sw_en all ones.
- NSTG=1: a single stage; UP/DOWN last STG_DLY cycles.

Test Plan:
- Power-up with defaults: reset low, pwr_req rises and is sampled at E0 -> sw_en 0001@E0, 0011@E8, 0111@E16, 1111@E24; dom_reset falls @E36; ret_restore high E36–E37 only; iso_en falls and pwr_ack rises @E39; busy high E0–E38.
- Power-down from ON with defaults: pwr_req falls, sampled at E0 -> pwr_ack=0 and iso_en=1 @E0; ret_save high E2–E3; dom_reset=1 and sw_en=0111 @E3; 0011@E11, 0001@E19, 0000@E27; OFF with busy=0 @E35.
- Request reversal: pwr_req drops at E10 of power-up -> power-up completes (pwr_ack=1 @E39), then ISO entered on the next edge and the full power-down follows.
- Async reset mid-UP: reset asserted between edges at E13 -> outputs return to reset values immediately without a clock edge; ret_save is never pulsed; after release with pwr_req=1 the sequence restarts from sw_en=0001.
- Edge parameters NSTG=1, STG_DLY=1, RST_DLY=1, ISO_DLY=1: power-up -> pwr_ack @E4; power-down -> OFF @E3; ret pulses each exactly one cycle.
- Invariant sweep: random pwr_req toggling and random resets for 10k cycles -> no isolation, thermometer or ack invariant violated.

Source files
------------

// File: rtl/scs8hd_pgate_seq.sv
// Power-gating sequencer for one switchable scs8hd domain: ramps the header
// switches stage by stage, then sequences domain reset, retention and isolation.
module scs8hd_pgate_seq #(
  parameter int NSTG    = 4,
  parameter int STG_DLY = 8,
  parameter int RST_DLY = 4,
  parameter int ISO_DLY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwr_req,
  output logic            pwr_ack,
  output logic [NSTG-1:0] sw_en,
  output logic            iso_en,
  output logic            dom_reset,
  output logic            ret_restore,
  output logic            ret_save,
  output logic            busy
);

  localparam int UP_CYC  = NSTG * STG_DLY;
  localparam int MAX_A   = (UP_CYC > RST_DLY) ? UP_CYC : RST_DLY;
  localparam int MAX_DLY = (MAX_A > ISO_DLY) ? MAX_A : ISO_DLY;
  localparam int CW      = $clog2(MAX_DLY + 1);
  localparam int IW      = (NSTG > 1) ? $clog2(NSTG) : 1;

  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   STG_LD   = CW'(STG_DLY - 1);
  localparam logic [CW-1:0]   RST_LD   = CW'(RST_DLY - 1);
  localparam logic [CW-1:0]   ISO_LD   = CW'(ISO_DLY - 1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_TOP  = IW'(NSTG - 1);
  localparam logic [NSTG-1:0] SW_NONE  = NSTG'(0);
  localparam logic [NSTG-1:0] SW_ONE   = NSTG'(1);

  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_UP      = 4'd1,
    S_RST     = 4'd2,
    S_RESTORE = 4'd3,
    S_UNISO   = 4'd4,
    S_ON      = 4'd5,
    S_ISO     = 4'd6,
    S_SAVE    = 4'd7,
    S_DOWN    = 4'd8
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [NSTG-1:0] sw_en_r, sw_en_s;
  logic            iso_en_r, iso_en_s;
  logic            dom_reset_r, dom_reset_s;
  logic            ret_restore_r, ret_restore_s;
  logic            ret_save_r, ret_save_s;
  logic            pwr_ack_r, pwr_ack_s;
  logic            busy_r, busy_s;
  logic            cnt_done_s;
  logic [CW-1:0]   cnt_dec_s;

  assign cnt_done_s = (cnt_r == CNT_ZERO);
  assign cnt_dec_s  = cnt_r - CNT_ONE;

  // Next-state and next-output decode; outputs are computed one edge ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    sw_en_s       = sw_en_r;
    iso_en_s      = iso_en_r;
    dom_reset_s   = dom_reset_r;
    ret_restore_s = 1'b0;
    ret_save_s    = 1'b0;
    pwr_ack_s     = pwr_ack_r;
    case (state_r)
      S_OFF: begin
        if (pwr_req) begin
          state_s = S_UP;
          sw_en_s = SW_ONE;
          idx_s   = IDX_ZERO;
          cnt_s   = STG_LD;
        end else begin
          sw_en_s = SW_NONE;
        end
      end
      S_UP: begin
        // Counter times one stage; the index tracks which stage is settling.
        if (cnt_done_s) begin
          if (idx_r == IDX_TOP) begin
            state_s = S_RST;
            cnt_s   = RST_LD;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            cnt_s   = STG_LD;
            sw_en_s = (sw_en_r << 1'b1) | SW_ONE;
          end
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      S_RST: begin
        if (cnt_done_s) begin
          state_s       = S_RESTORE;
          dom_reset_s   = 1'b0;
          ret_restore_s = 1'b1;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      S_RESTORE: begin
        state_s = S_UNISO;
        cnt_s   = ISO_LD;
      end
      S_UNISO: begin
        if (cnt_done_s) begin
          state_s   = S_ON;
          iso_en_s  = 1'b0;
          pwr_ack_s = 1'b1;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          state_s   = S_ISO;
          pwr_ack_s = 1'b0;
          iso_en_s  = 1'b1;
          cnt_s     = ISO_LD;
        end else begin
          pwr_ack_s = 1'b1;
        end
      end
      S_ISO: begin
        if (cnt_done_s) begin
          state_s    = S_SAVE;
          ret_save_s = 1'b1;
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      S_SAVE: begin
        state_s     = S_DOWN;
        dom_reset_s = 1'b1;
        sw_en_s     = sw_en_r >> 1'b1;
        idx_s       = IDX_TOP;
        cnt_s       = STG_LD;
      end
      S_DOWN: begin
        // Top stage already dropped on entry; bit 0 is the last to go.
        if (cnt_done_s) begin
          if (idx_r == IDX_ZERO) begin
            state_s = S_OFF;
          end else begin
            idx_s   = idx_r - IDX_ONE;
            cnt_s   = STG_LD;
            sw_en_s = sw_en_r >> 1'b1;
          end
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      default: begin
        state_s     = S_OFF;
        cnt_s       = CNT_ZERO;
        idx_s       = IDX_ZERO;
        sw_en_s     = SW_NONE;
        iso_en_s    = 1'b1;
        dom_reset_s = 1'b1;
        pwr_ack_s   = 1'b0;
      end
    endcase
    busy_s = (state_s != S_OFF) && (state_s != S_ON);
  end

  // State, counter and output registers; reset forces the safe OFF values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_OFF;
      cnt_r         <= CNT_ZERO;
      idx_r         <= IDX_ZERO;
      sw_en_r       <= SW_NONE;
      iso_en_r      <= 1'b1;
      dom_reset_r   <= 1'b1;
      ret_restore_r <= 1'b0;
      ret_save_r    <= 1'b0;
      pwr_ack_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      sw_en_r       <= sw_en_s;
      iso_en_r      <= iso_en_s;
      dom_reset_r   <= dom_reset_s;
      ret_restore_r <= ret_restore_s;
      ret_save_r    <= ret_save_s;
      pwr_ack_r     <= pwr_ack_s;
      busy_r        <= busy_s;
    end
  end

  assign sw_en       = sw_en_r;
  assign iso_en      = iso_en_r;
  assign dom_reset   = dom_reset_r;
  assign ret_restore = ret_restore_r;
  assign ret_save    = ret_save_r;
  assign pwr_ack     = pwr_ack_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_scs8hd_pgate_seq.sv
// Directed bench for scs8hd_pgate_seq: default instance plus a minimum-parameter
// instance, cycle-exact sequences, async reset abort and an invariant sweep.
module tb_scs8hd_pgate_seq;

  logic       clk = 1'b0;
  logic       reset, pwr_req, reset1, pwr_req1;
  logic       pwr_ack, iso_en, dom_reset, ret_restore, ret_save, busy;
  logic [3:0] sw_en;
  logic       pwr_ack1, iso_en1, dom_reset1, ret_restore1, ret_save1, busy1;
  logic [0:0] sw_en1;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  scs8hd_pgate_seq u_dut (
    .clk(clk), .reset(reset), .pwr_req(pwr_req), .pwr_ack(pwr_ack),
    .sw_en(sw_en), .iso_en(iso_en), .dom_reset(dom_reset),
    .ret_restore(ret_restore), .ret_save(ret_save), .busy(busy)
  );

  scs8hd_pgate_seq #(.NSTG(1), .STG_DLY(1), .RST_DLY(1), .ISO_DLY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .pwr_req(pwr_req1), .pwr_ack(pwr_ack1),
    .sw_en(sw_en1), .iso_en(iso_en1), .dom_reset(dom_reset1),
    .ret_restore(ret_restore1), .ret_save(ret_save1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic inv_ok(input logic [31:0] sw, input logic [31:0] all,
                                  input logic iso, input logic dom, input logic ack,
                                  input logic rr, input logic rs);
    logic ok;
    ok = 1'b1;
    if (((sw != all) || dom) && !iso) ok = 1'b0;
    if (rr && rs) ok = 1'b0;
    if (((sw + 32'd1) & sw) != 32'd0) ok = 1'b0;
    if (ack && (sw != all)) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    reset = 1'b0; pwr_req = 1'b0; reset1 = 1'b0; pwr_req1 = 1'b0;
    #1;
    reset = 1'b1; reset1 = 1'b1;
    #1;
    check("rst_sw", {28'd0, sw_en}, 32'h0);
    check("rst_iso", {31'd0, iso_en}, 32'd1);
    check("rst_dom", {31'd0, dom_reset}, 32'd1);
    check("rst_ack", {31'd0, pwr_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ret", {30'd0, ret_save, ret_restore}, 32'd0);
    check("rst1_sw", {31'd0, sw_en1}, 32'd0);
    @(negedge clk);
    reset = 1'b0; reset1 = 1'b0;
    edge_step();
    check("off_hold_busy", {31'd0, busy}, 32'd0);

    // Power-up with defaults.
    pwr_req = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      edge_step();
      check($sformatf("pu_sw@E%0d", e), {28'd0, sw_en},
            (e < 8) ? 32'h1 : (e < 16) ? 32'h3 : (e < 24) ? 32'h7 : 32'hF);
      check($sformatf("pu_dom@E%0d", e), {31'd0, dom_reset}, (e < 36) ? 32'd1 : 32'd0);
      check($sformatf("pu_rr@E%0d", e), {31'd0, ret_restore}, (e == 36) ? 32'd1 : 32'd0);
      check($sformatf("pu_iso@E%0d", e), {31'd0, iso_en}, (e < 39) ? 32'd1 : 32'd0);
      check($sformatf("pu_ack@E%0d", e), {31'd0, pwr_ack}, (e >= 39) ? 32'd1 : 32'd0);
      check($sformatf("pu_busy@E%0d", e), {31'd0, busy}, (e < 39) ? 32'd1 : 32'd0);
      check($sformatf("pu_rs@E%0d", e), {31'd0, ret_save}, 32'd0);
    end

    // Power-down from ON with defaults.
    pwr_req = 1'b0;
    for (int e = 0; e <= 36; e++) begin
      edge_step();
      check($sformatf("pd_sw@E%0d", e), {28'd0, sw_en},
            (e < 3) ? 32'hF : (e < 11) ? 32'h7 : (e < 19) ? 32'h3 : (e < 27) ? 32'h1 : 32'h0);
      check($sformatf("pd_ack@E%0d", e), {31'd0, pwr_ack}, 32'd0);
      check($sformatf("pd_iso@E%0d", e), {31'd0, iso_en}, 32'd1);
      check($sformatf("pd_rs@E%0d", e), {31'd0, ret_save}, (e == 2) ? 32'd1 : 32'd0);
      check($sformatf("pd_dom@E%0d", e), {31'd0, dom_reset}, (e >= 3) ? 32'd1 : 32'd0);
      check($sformatf("pd_busy@E%0d", e), {31'd0, busy}, (e < 35) ? 32'd1 : 32'd0);
    end

    // Request reversal during power-up.
    pwr_req = 1'b1;
    for (int e = 0; e <= 76; e++) begin
      edge_step();
      if (e == 10) pwr_req = 1'b0;
      if (e == 39) check("rev_ack@E39", {31'd0, pwr_ack}, 32'd1);
      if (e == 40) begin
        check("rev_ack@E40", {31'd0, pwr_ack}, 32'd0);
        check("rev_iso@E40", {31'd0, iso_en}, 32'd1);
        check("rev_busy@E40", {31'd0, busy}, 32'd1);
      end
      if (e == 42) check("rev_rs@E42", {31'd0, ret_save}, 32'd1);
      if (e == 43) check("rev_sw@E43", {28'd0, sw_en}, 32'h7);
      if (e == 75) check("rev_busy@E75", {31'd0, busy}, 32'd0);
      if (e == 76) check("rev_sw@E76", {28'd0, sw_en}, 32'h0);
    end

    // Async reset mid-UP.
    pwr_req = 1'b1;
    for (int e = 0; e <= 13; e++) edge_step();
    check("ar_sw_pre", {28'd0, sw_en}, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_sw", {28'd0, sw_en}, 32'h0);
    check("ar_iso", {31'd0, iso_en}, 32'd1);
    check("ar_dom", {31'd0, dom_reset}, 32'd1);
    check("ar_busy", {31'd0, busy}, 32'd0);
    edge_step();
    check("ar_rs_hold", {31'd0, ret_save}, 32'd0);
    check("ar_sw_hold", {28'd0, sw_en}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    edge_step();
    check("ar_restart_sw", {28'd0, sw_en}, 32'h1);
    check("ar_restart_busy", {31'd0, busy}, 32'd1);
    for (int e = 1; e <= 8; e++) edge_step();
    check("ar_restart_sw8", {28'd0, sw_en}, 32'h3);
    reset = 1'b1; pwr_req = 1'b0;
    #2;
    reset = 1'b0;

    // Minimum parameters: NSTG=1, all delays 1.
    pwr_req1 = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      edge_step();
      check($sformatf("e1u_sw@E%0d", e), {31'd0, sw_en1}, 32'd1);
      check($sformatf("e1u_dom@E%0d", e), {31'd0, dom_reset1}, (e < 2) ? 32'd1 : 32'd0);
      check($sformatf("e1u_rr@E%0d", e), {31'd0, ret_restore1}, (e == 2) ? 32'd1 : 32'd0);
      check($sformatf("e1u_ack@E%0d", e), {31'd0, pwr_ack1}, (e >= 4) ? 32'd1 : 32'd0);
      check($sformatf("e1u_iso@E%0d", e), {31'd0, iso_en1}, (e < 4) ? 32'd1 : 32'd0);
      check($sformatf("e1u_busy@E%0d", e), {31'd0, busy1}, (e < 4) ? 32'd1 : 32'd0);
    end
    pwr_req1 = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      edge_step();
      check($sformatf("e1d_sw@E%0d", e), {31'd0, sw_en1}, (e < 2) ? 32'd1 : 32'd0);
      check($sformatf("e1d_rs@E%0d", e), {31'd0, ret_save1}, (e == 1) ? 32'd1 : 32'd0);
      check($sformatf("e1d_dom@E%0d", e), {31'd0, dom_reset1}, (e >= 2) ? 32'd1 : 32'd0);
      check($sformatf("e1d_ack@E%0d", e), {31'd0, pwr_ack1}, 32'd0);
      check($sformatf("e1d_iso@E%0d", e), {31'd0, iso_en1}, 32'd1);
      check($sformatf("e1d_busy@E%0d", e), {31'd0, busy1}, (e < 3) ? 32'd1 : 32'd0);
    end

    // Invariant sweep with random requests and resets on both instances.
    for (int c = 0; c < 10000; c++) begin
      edge_step();
      check("inv4", {31'd0, inv_ok({28'd0, sw_en}, 32'hF, iso_en, dom_reset, pwr_ack,
                                   ret_restore, ret_save)}, 32'd1);
      check("inv1", {31'd0, inv_ok({31'd0, sw_en1}, 32'h1, iso_en1, dom_reset1, pwr_ack1,
                                   ret_restore1, ret_save1)}, 32'd1);
      if ($urandom_range(0, 39) == 0) pwr_req = ~pwr_req;
      if ($urandom_range(0, 9) == 0) pwr_req1 = ~pwr_req1;
      reset  = ($urandom_range(0, 299) == 0);
      reset1 = ($urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
